// File: rtl/serial_adder_if.sv
// rtl/serial_adder_if.sv - start/busy/done handshake and operand/result bundle for serial_adder
//
// Purpose: groups the operand request side (start, a, b, cin) and the result
// side (busy, done, sum, cout) of the bit-serial adder into one port.
// Ports (signals):
//   start  request to begin an addition
//   a, b   WIDTH-bit operands
//   cin    carry-in
//   busy   high while bits are being computed
//   done   one-cycle completion pulse
//   sum    WIDTH-bit result
//   cout   final carry
// Modports: master drives the request and observes the result, slave is the adder.

interface serial_adder_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;

   modport master (
      output start, a, b, cin,
      input  busy, done, sum, cout
   );

   modport slave (
      input  start, a, b, cin,
      output busy, done, sum, cout
   );
endinterface

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial WIDTH-bit adder built from two half adders and a carry flop
//
// Purpose: latches a, b and cin on an accepted start, then adds LSB-first at one
// bit per clock. The result shifts into sum from the MSB end so that after WIDTH
// cycles sum holds the full word and cout the final carry.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    serial_adder_if slave: start/a/b/cin in, busy/done/sum/cout out

module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   serial_adder_if.slave bus
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] sa_q, sa_d;
   logic [WIDTH-1:0] sb_q, sb_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             carry_q, carry_d;
   logic             cout_q, cout_d;
   logic [CW-1:0]    count_q, count_d;

   // Full adder as two cascaded half adders on the current LSBs.
   logic p, g1, s, g2, carry_next, last_bit;

   assign p          = sa_q[0] ^ sb_q[0];
   assign g1         = sa_q[0] & sb_q[0];
   assign s          = p ^ carry_q;
   assign g2         = p & carry_q;
   assign carry_next = g1 | g2;
   assign last_bit   = (count_q == CW'(WIDTH - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         sa_q    <= '0;
         sb_q    <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         sa_q    <= sa_d;
         sb_q    <= sb_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         count_q <= count_d;
      end
   end

   always_comb begin
      state_d = state_q;
      sa_d    = sa_q;
      sb_d    = sb_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      count_d = count_q;

      unique case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               sa_d    = bus.a;
               sb_d    = bus.b;
               carry_d = bus.cin;
               count_d = '0;
               sum_d   = '0;
               cout_d  = 1'b0;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            carry_d = carry_next;
            sum_d   = {s, sum_q[WIDTH-1:1]};
            sa_d    = sa_q >> 1;
            sb_d    = sb_q >> 1;
            if (last_bit) begin
               // Hold count at WIDTH-1 rather than letting it wrap on the final bit.
               cout_d  = carry_next;
               state_d = ST_DONE;
            end else begin
               count_d = count_q + CW'(1);
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Decoded straight from the state flop so reset clears them without a clock.
   assign bus.busy = (state_q == ST_RUN);
   assign bus.done = (state_q == ST_DONE);
   assign bus.sum  = sum_q;
   assign bus.cout = cout_q;

endmodule
